tdm_frame_ctrl: RTL and testbench
=================================

# tdm_frame_ctrl

Frame controller for the TDM-to-MCU converter path. Tracks the TDM frame on `f0`/`c4`, captures one frame of `data_from_dt` into a double buffer, signals the STM32 via `cpu_int`, and serves the completed frame bit-serially on `clk_from_stm`. All logic runs on `clk50`. TDM and STM pins are asynchronous and are synchronised inside the block.

## Interface
- `FRAME_BITS`, default 256: bits per TDM frame and per buffer bank.
- `C4_PER_BIT`, default 2: `c4` cycles per data bit.
- `MISS_LIMIT`, default 2: consecutive missing `f0` pulses before leaving LOCKED.
- `clk50`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: synchronous, active-high reset.
- `f0`, in, 1: frame pulse, active-low, asynchronous.
- `c4`, in, 1: TDM clock, asynchronous.
- `data_from_dt`, in, 1: TDM serial data.
- `select`, in, 1: capture enable, sampled at each frame start.
- `clk_from_stm`, in, 1: readout shift clock from STM, asynchronous.
- `clr_err`, in, 1: one-cycle pulse that clears `overrun` and `sync_lost`.
- `data_to_stm`, out, 1: readout serial data.
- `cpu_int`, out, 1: high while a completed frame awaits readout.
- `overrun`, out, 1: sticky; a frame was dropped because readout was still pending.
- `sync_lost`, out, 1: sticky; a frame pulse was misplaced, or the miss limit was reached.

## Operation
- **Synchronisers.** `f0`, `c4`, `data_from_dt` and `clk_from_stm` each pass through 2 flops, plus a third flop for edge detection. This produces the strobes `c4_rise` and `stm_fall` and the synchronised levels `f0_s` and `d_s`.
- **Counters.** `ph` counts 0..C4_PER_BIT-1. `bit_cnt` counts 0..FRAME_BITS-1.
- **FSM states:** HUNT, LOCKED.
- **HUNT**
  - `c4_rise` with `f0_s==0`: set `ph=0`, `bit_cnt=0`, `miss=0`, latch `select` into `cap_en`, go to LOCKED.
  - Data is ignored.
- **LOCKED**, on each `c4_rise`:
  - If `ph==C4_PER_BIT-1`: if `cap_en`, write `d_s` into the capture bank at index `bit_cnt`. Then `ph=0` and `bit_cnt++`.
  - Otherwise: `ph++`.
  - After the write at `bit_cnt==FRAME_BITS-1`, assert the internal `frame_done`. `bit_cnt` wraps to 0 (flywheel).
  - Expected frame pulse: `f0_s==0` at the `c4_rise` where `bit_cnt==0` and `ph==0`. On it: `miss=0`, re-latch `cap_en`.
  - If `f0_s` is high at that point: `miss++` and the frame continues by flywheel. When `miss==MISS_LIMIT`, set `sync_lost` and go to HUNT.
  - `f0_s==0` at any other position: set `sync_lost`, discard the partial frame, re-align as from HUNT, stay LOCKED.
- **Banks.** Two banks of FRAME_BITS bits; `wr_bank` and `rd_bank = !wr_bank`.
  - On `frame_done` with `cap_en` and `rd_full==0`: toggle `wr_bank`, set `rd_full=1`, reset `rd_idx=0`.
  - On `frame_done` with `cap_en` and `rd_full==1`: set `overrun`, do not swap. The next frame overwrites the capture bank.
  - On `frame_done` with `cap_en==0`: no action.
- **Readout.**
  - `data_to_stm = rd_bank[rd_idx]` when `rd_full`, else 0.
  - On `stm_fall` with `rd_full`: `rd_idx++`. After the FRAME_BITS-th edge, `rd_full=0`.
  - `stm_fall` with `rd_full==0` is ignored.
- `cpu_int = rd_full`.
- **Simultaneous events**
  - The final readout edge and `frame_done` in the same `clk50` cycle: the readout completes first, so the swap succeeds, there is no overrun, and `cpu_int` stays 1.
  - `clr_err` together with a set event: the set wins.
- **Widths.** `bit_cnt` and `rd_idx` are `$clog2(FRAME_BITS)` bits wide. Bit 0 is the first bit received and the first bit shifted out.

## Timing
- **Reset values:** `data_to_stm=0`, `cpu_int=0`, `overrun=0`, `sync_lost=0`, state=HUNT, counters 0, `rd_full=0`, `wr_bank=0`. Bank contents are not reset.
- Reset asserted mid-frame or mid-readout aborts everything. The first action afterwards needs a fresh `f0`.
- Pin edge to internal strobe: 3 `clk50` cycles.
- Sample to bank write: same cycle as `c4_rise`.
- `frame_done` to `cpu_int` high: 1 `clk50` cycle.
- Pin `clk_from_stm` fall to new `data_to_stm`: at most 4 `clk50` cycles. The STM samples on its rising edge.
- Last readout edge to `cpu_int` low: 1 `clk50` cycle after the strobe.
- Supported ranges: `c4` up to 8.192 MHz; `clk_from_stm` up to 10 MHz (each level held at least 2 `clk50` cycles).

## Test plan
- **Lock and capture.** Reset, then `f0` pulse, then 256 bits of pattern 0xA5 repeated, `select=1`. Require `cpu_int=1` about 1 `clk50` cycle after the 256th bit. Clock 256 STM falls; require `data_to_stm` to reproduce 0xA5… in order and `cpu_int` to return to 0.
- **Overrun.** Two consecutive frames with no readout. Require `overrun=1` after frame 2 and readout to return frame 1 data. `clr_err` pulse → `overrun=0`.
- **Missing f0.** Lock, then omit `f0` for 1 frame: frame still captured, `sync_lost=0`. Omit `f0` for 2 frames: `sync_lost=1`, state HUNT, no further `cpu_int`.
- **Misplaced f0.** `f0` at bit 100. Require `sync_lost=1`, no `cpu_int` for the partial frame, and the next full frame captured correctly.
- **Simultaneous events.** Final STM edge coincides with `frame_done`: `overrun=0`, `cpu_int` stays 1, the new frame is read out.
- **Reset and select.** `reset` at readout bit 50 → all outputs 0, state HUNT. `select=0` at frame start → no `cpu_int` and no overrun for that frame.

Source files
------------

// File: rtl/tdm_frame_ctrl.sv
// rtl/tdm_frame_ctrl.sv - TDM frame tracker with double-buffered capture and bit-serial STM readout
module tdm_frame_ctrl #(
  parameter int FRAME_BITS = 256,
  parameter int C4_PER_BIT = 2,
  parameter int MISS_LIMIT = 2
) (
  input  logic clk50,
  input  logic reset,
  input  logic f0,
  input  logic c4,
  input  logic data_from_dt,
  input  logic select,
  input  logic clk_from_stm,
  input  logic clr_err,
  output logic data_to_stm,
  output logic cpu_int,
  output logic overrun,
  output logic sync_lost
);

  localparam int BW = $clog2(FRAME_BITS);
  localparam int PW = (C4_PER_BIT > 1) ? $clog2(C4_PER_BIT) : 1;
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(C4_PER_BIT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [1:0]      f0_sr, d_sr;
  logic [2:0]      c4_sr, stm_sr;
  logic            c4_rise, stm_fall, f0_s, d_s;
  logic [PW-1:0]   ph;
  logic [BW-1:0]   bit_cnt;
  logic [MW-1:0]   miss;
  logic            cap_en;
  logic            at_start, align, step, relatch, miss_inc, set_sync;
  logic            frame_done, wr_en, rd_done;
  logic            wr_bank, rd_full;
  logic [BW-1:0]   rd_idx;
  logic [FRAME_BITS-1:0] bank [2];
  logic [FRAME_BITS-1:0] rd_word;

  // f0 and data share the c4 second stage so they line up with c4_rise
  always_ff @(posedge clk50) begin
    if (reset) begin
      f0_sr  <= '1;
      d_sr   <= '0;
      c4_sr  <= '0;
      stm_sr <= '0;
    end else begin
      f0_sr  <= {f0_sr[0], f0};
      d_sr   <= {d_sr[0], data_from_dt};
      c4_sr  <= {c4_sr[1:0], c4};
      stm_sr <= {stm_sr[1:0], clk_from_stm};
    end
  end

  assign c4_rise  = c4_sr[1] & ~c4_sr[2];
  assign stm_fall = stm_sr[2] & ~stm_sr[1];
  assign f0_s     = f0_sr[1];
  assign d_s      = d_sr[1];
  assign at_start = (bit_cnt == '0) && (ph == '0);

  always_ff @(posedge clk50) begin
    if (reset) state <= HUNT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    align     = 1'b0;
    step      = 1'b0;
    relatch   = 1'b0;
    miss_inc  = 1'b0;
    set_sync  = 1'b0;
    case (state)
      HUNT: begin
        if (c4_rise && !f0_s) begin
          align     = 1'b1;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (c4_rise) begin
          if (!at_start && !f0_s) begin
            set_sync = 1'b1;
            align    = 1'b1;
          end else if (at_start && !f0_s) begin
            step    = 1'b1;
            relatch = 1'b1;
          end else if (at_start && (miss == MISS_LAST)) begin
            set_sync  = 1'b1;
            state_nxt = HUNT;
          end else begin
            step     = 1'b1;
            miss_inc = at_start;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  assign frame_done = step && (ph == PH_LAST) && (bit_cnt == BIT_LAST);
  assign wr_en      = !reset && step && (ph == PH_LAST) && (relatch ? select : cap_en);

  always_ff @(posedge clk50) begin
    if (reset) begin
      ph      <= '0;
      bit_cnt <= '0;
      miss    <= '0;
      cap_en  <= 1'b0;
    end else if (align) begin
      ph      <= '0;
      bit_cnt <= '0;
      miss    <= '0;
      cap_en  <= select;
    end else if (step) begin
      if (relatch) begin
        miss   <= '0;
        cap_en <= select;
      end else if (miss_inc) begin
        miss <= miss + 1'b1;
      end
      if (ph == PH_LAST) begin
        ph      <= '0;
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end else begin
        ph <= ph + 1'b1;
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (wr_en) bank[wr_bank][bit_cnt] <= d_s;
  end

  assign rd_word = bank[!wr_bank];
  assign rd_done = stm_fall && rd_full && (rd_idx == BIT_LAST);

  // Readout bookkeeping runs before the swap decision so a coincident final edge frees the bank
  always_ff @(posedge clk50) begin
    if (reset) begin
      wr_bank   <= 1'b0;
      rd_full   <= 1'b0;
      rd_idx    <= '0;
      overrun   <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      if (clr_err) begin
        overrun   <= 1'b0;
        sync_lost <= 1'b0;
      end
      if (set_sync) sync_lost <= 1'b1;
      if (stm_fall && rd_full) begin
        rd_idx <= rd_done ? '0 : rd_idx + 1'b1;
        if (rd_done) rd_full <= 1'b0;
      end
      if (frame_done && cap_en) begin
        if (!rd_full || rd_done) begin
          wr_bank <= ~wr_bank;
          rd_full <= 1'b1;
          rd_idx  <= '0;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign data_to_stm = rd_full ? rd_word[rd_idx] : 1'b0;
  assign cpu_int     = rd_full;

endmodule

// File: tb/tb_tdm_frame_ctrl.sv
// tb/tb_tdm_frame_ctrl.sv - directed bench for tdm_frame_ctrl
module tb_tdm_frame_ctrl;

  logic clk50 = 1'b0;
  logic reset, f0, c4, data_from_dt, select, clk_from_stm, clr_err;
  logic data_to_stm, cpu_int, overrun, sync_lost;
  int   total = 0;
  int   bad   = 0;

  localparam logic [255:0] PA = {32{8'hA5}};
  localparam logic [255:0] PB = {8{32'hDEADBEEF}};
  localparam logic [255:0] PC = {16{16'h1234}};
  localparam logic [255:0] PD = {4{64'h0F1E2D3C4B5A6978}};

  always #10 clk50 = ~clk50;

  tdm_frame_ctrl dut (
    .clk50        (clk50),
    .reset        (reset),
    .f0           (f0),
    .c4           (c4),
    .data_from_dt (data_from_dt),
    .select       (select),
    .clk_from_stm (clk_from_stm),
    .clr_err      (clr_err),
    .data_to_stm  (data_to_stm),
    .cpu_int      (cpu_int),
    .overrun      (overrun),
    .sync_lost    (sync_lost)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic c4_cycle(input logic f0_val, input logic d, input logic stm_on_rise);
    f0 = f0_val;
    data_from_dt = d;
    c4 = 1'b0;
    wait_clk(3);
    c4 = 1'b1;
    if (stm_on_rise) clk_from_stm = 1'b0;
    wait_clk(3);
    f0 = 1'b1;
  endtask

  task automatic lock_pulse();
    c4_cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [255:0] v, input int n, input logic with_f0, input logic stm_last);
    for (int i = 0; i < n; i++) begin
      for (int p = 0; p < 2; p++) begin
        c4_cycle((with_f0 && i == 0 && p == 0) ? 1'b0 : 1'b1, v[i],
                 (stm_last && i == n - 1 && p == 1) ? 1'b1 : 1'b0);
      end
    end
    c4 = 1'b0;
    clk_from_stm = 1'b1;
    wait_clk(4);
  endtask

  task automatic read_bits(input int n, output logic [255:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v[i] = data_to_stm;
      clk_from_stm = 1'b0;
      wait_clk(4);
      clk_from_stm = 1'b1;
      wait_clk(4);
    end
    wait_clk(2);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
    wait_clk(1);
  endtask

  logic [255:0] v;
  logic [255:0] m;

  initial begin
    reset = 1'b1; f0 = 1'b1; c4 = 1'b0; data_from_dt = 1'b0;
    select = 1'b1; clk_from_stm = 1'b1; clr_err = 1'b0;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    check("rst_cpu_int", 256'(cpu_int), 256'(0));
    check("rst_overrun", 256'(overrun), 256'(0));
    check("rst_sync_lost", 256'(sync_lost), 256'(0));
    check("rst_data", 256'(data_to_stm), 256'(0));
    check("rst_state", 256'(dut.state), 256'(0));

    // lock and capture
    lock_pulse();
    send_bits(PA, 256, 1'b1, 1'b0);
    check("cap_cpu_int", 256'(cpu_int), 256'(1));
    read_bits(256, v);
    check("cap_data", v, PA);
    check("cap_cpu_int_clr", 256'(cpu_int), 256'(0));

    // overrun
    send_bits(PB, 256, 1'b1, 1'b0);
    check("ovr_first_int", 256'(cpu_int), 256'(1));
    check("ovr_first_flag", 256'(overrun), 256'(0));
    send_bits(PC, 256, 1'b1, 1'b0);
    check("ovr_flag", 256'(overrun), 256'(1));
    read_bits(256, v);
    check("ovr_data", v, PB);
    pulse_clr();
    check("ovr_clr", 256'(overrun), 256'(0));
    check("ovr_sync", 256'(sync_lost), 256'(0));

    // missing f0: one frame flywheels, the second drops lock
    send_bits(PD, 256, 1'b0, 1'b0);
    check("miss1_int", 256'(cpu_int), 256'(1));
    check("miss1_sync", 256'(sync_lost), 256'(0));
    read_bits(256, v);
    check("miss1_data", v, PD);
    send_bits(PA, 256, 1'b0, 1'b0);
    check("miss2_sync", 256'(sync_lost), 256'(1));
    check("miss2_int", 256'(cpu_int), 256'(0));
    check("miss2_state", 256'(dut.state), 256'(0));
    pulse_clr();

    // misplaced f0 at bit 100
    lock_pulse();
    send_bits(PA, 100, 1'b1, 1'b0);
    lock_pulse();
    wait_clk(4);
    check("misp_sync", 256'(sync_lost), 256'(1));
    check("misp_int", 256'(cpu_int), 256'(0));
    send_bits(PB, 256, 1'b1, 1'b0);
    check("misp_next_int", 256'(cpu_int), 256'(1));
    read_bits(256, v);
    check("misp_next_data", v, PB);
    pulse_clr();
    check("misp_clr", 256'(sync_lost), 256'(0));

    // final readout edge coincides with frame_done
    send_bits(PC, 256, 1'b1, 1'b0);
    read_bits(255, v);
    m = PC;
    m[255] = 1'b0;
    check("sim_part", v, m);
    send_bits(PD, 256, 1'b1, 1'b1);
    check("sim_overrun", 256'(overrun), 256'(0));
    check("sim_int", 256'(cpu_int), 256'(1));
    read_bits(256, v);
    check("sim_data", v, PD);
    check("sim_int_clr", 256'(cpu_int), 256'(0));

    // reset in the middle of a readout
    send_bits(PA, 256, 1'b1, 1'b0);
    send_bits(PB, 256, 1'b1, 1'b0);
    read_bits(50, v);
    check("pre_rst_data", 256'(data_to_stm), 256'(1));
    check("pre_rst_ovr", 256'(overrun), 256'(1));
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(1);
    check("mid_rst_int", 256'(cpu_int), 256'(0));
    check("mid_rst_ovr", 256'(overrun), 256'(0));
    check("mid_rst_data", 256'(data_to_stm), 256'(0));
    check("mid_rst_state", 256'(dut.state), 256'(0));

    // select low at frame start
    select = 1'b0;
    lock_pulse();
    send_bits(PC, 256, 1'b1, 1'b0);
    check("nosel_int", 256'(cpu_int), 256'(0));
    check("nosel_ovr", 256'(overrun), 256'(0));
    select = 1'b1;
    send_bits(PB, 256, 1'b1, 1'b0);
    check("sel_again_int", 256'(cpu_int), 256'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
